// File: rtl/uni_shift_pkg.sv
// Shared op codes, shift-register mode selects and FSM state type for uni_shift_ctrl.
package uni_shift_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

  // ROTR moves bits toward the LSB, same register mode as SHR.
  function automatic logic [1:0] shift_sel(input logic [1:0] op);
    return (op == OP_SHL) ? SEL_SHL : SEL_SHR;
  endfunction

endpackage

// File: rtl/shift_cnt.sv
// Loadable down-counter for the remaining shift count; last flags remaining == 1.
module shift_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/uni_shift_ctrl.sv
// Command sequencer for an 8-bit universal shift register.
// Define UNI_SHIFT_ROTATE_EN to build the ROTR feedback path; otherwise op 11 reports err.
module uni_shift_ctrl
  import uni_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_parallel_in,
  output logic             sr_serial_in_L,
  output logic             sr_serial_in_R,
  input  logic             sr_serial_out_L,
  input  logic             sr_serial_out_R,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out_bits
);

`ifdef UNI_SHIFT_ROTATE_EN
  localparam bit RotateEn = 1'b1;
`else
  localparam bit RotateEn = 1'b0;
`endif

  state_e           state_q;
  logic [1:0]       op_q;
  logic             fill_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] out_bits_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic accept;
  logic cnt_last;
  logic cmd_unsup;

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_unsup = (cmd_op == OP_ROTR) && !RotateEn;

  shift_cnt #(
    .CNT_W (CNT_W)
  ) u_shift_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (cmd_count),
    .dec      (state_q == StShift),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OP_LOAD;
      fill_q     <= 1'b0;
      data_q     <= '0;
      out_bits_q <= '0;
      sel_q      <= SEL_HOLD;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q       <= cmd_op;
            fill_q     <= cmd_fill;
            data_q     <= cmd_data;
            out_bits_q <= '0;
            busy_q     <= 1'b1;
            if (cmd_op == OP_LOAD) begin
              state_q <= StLoad;
              sel_q   <= SEL_LOAD;
            end else if ((cmd_count == '0) || cmd_unsup) begin
              state_q <= StDone;
              sel_q   <= SEL_HOLD;
              done_q  <= 1'b1;
              err_q   <= cmd_unsup;
            end else begin
              state_q <= StShift;
              sel_q   <= shift_sel(cmd_op);
            end
          end
        end
        StLoad: begin
          state_q <= StDone;
          sel_q   <= SEL_HOLD;
          done_q  <= 1'b1;
        end
        StShift: begin
          // Capture the bit leaving the register on this same edge.
          if (op_q == OP_SHL) begin
            out_bits_q <= {out_bits_q[WIDTH-2:0], sr_serial_out_L};
          end else begin
            out_bits_q <= {sr_serial_out_R, out_bits_q[WIDTH-1:1]};
          end
          if (cnt_last) begin
            state_q <= StDone;
            sel_q   <= SEL_HOLD;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          sel_q   <= SEL_HOLD;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sr_serial_in_L = 1'b0;
    sr_serial_in_R = 1'b0;
    if (state_q == StShift) begin
      case (op_q)
        OP_SHR:  sr_serial_in_R = fill_q;
        OP_SHL:  sr_serial_in_L = fill_q;
`ifdef UNI_SHIFT_ROTATE_EN
        OP_ROTR: sr_serial_in_R = sr_serial_out_R;
`endif
        default: ;
      endcase
    end
  end

  assign sr_sel         = sel_q;
  assign sr_parallel_in = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign out_bits       = out_bits_q;

endmodule

// File: tb/tb_uni_shift_ctrl.sv
// Bench for uni_shift_ctrl: attached register plant, stream-arithmetic model, per-cycle compare.
module tb_uni_shift_ctrl;

`ifdef UNI_SHIFT_ROTATE_EN
  localparam bit RotEn = 1'b1;
`else
  localparam bit RotEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_count = 4'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_fill = 1'b0;
  logic [1:0] sr_sel;
  logic [7:0] sr_parallel_in;
  logic       sr_serial_in_L, sr_serial_in_R;
  logic       busy, done, err;
  logic [7:0] out_bits;

  logic [7:0] plant_q;
  logic       plant_clr = 1'b1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uni_shift_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_count       (cmd_count),
    .cmd_data        (cmd_data),
    .cmd_fill        (cmd_fill),
    .sr_sel          (sr_sel),
    .sr_parallel_in  (sr_parallel_in),
    .sr_serial_in_L  (sr_serial_in_L),
    .sr_serial_in_R  (sr_serial_in_R),
    .sr_serial_out_L (plant_q[7]),
    .sr_serial_out_R (plant_q[0]),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .out_bits        (out_bits)
  );

  // The attached universal shift register, with its own clear.
  always @(posedge clk) begin
    if (plant_clr) plant_q <= 8'h00;
    else begin
      case (sr_sel)
        2'b01:   plant_q <= {sr_serial_in_R, plant_q[7:1]};
        2'b10:   plant_q <= {plant_q[6:0], sr_serial_in_L};
        2'b11:   plant_q <= sr_parallel_in;
        default: plant_q <= plant_q;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs after an accept.
  typedef struct packed {
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic       err;
    logic       rot;
    logic       in_r;
    logic       in_l;
  } exp_t;

  exp_t       eq[$];
  logic [7:0] last_data = 8'h00;
  logic [7:0] model_q = 8'h00;
  bit         chk_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      if (eq.size() > 0) e = eq.pop_front();
      else e = '0;
      check("sr_sel", {30'd0, sr_sel}, {30'd0, e.sel});
      check("busy", {31'd0, busy}, {31'd0, e.busy});
      check("done", {31'd0, done}, {31'd0, e.done});
      check("err", {31'd0, err}, {31'd0, e.err});
      check("cmd_ready", {31'd0, cmd_ready}, {31'd0, !e.busy});
      check("sr_serial_in_L", {31'd0, sr_serial_in_L}, {31'd0, e.in_l});
      check("sr_serial_in_R", {31'd0, sr_serial_in_R}, {31'd0, e.rot ? plant_q[0] : e.in_r});
      check("sr_parallel_in", {24'd0, sr_parallel_in}, {24'd0, last_data});
    end
  end

  // Shifting viewed as a bit stream: the register window slides over its own bits plus fill.
  task automatic model_cmd(input logic [1:0] op, input int n, input logic [7:0] q0,
                           input logic [7:0] data, input logic fill,
                           output logic [7:0] q1, output logic [7:0] o1);
    logic [7:0]  f8;
    logic [23:0] s, sv;
    logic [31:0] w, wv;
    f8 = fill ? 8'hFF : 8'h00;
    q1 = q0;
    o1 = 8'h00;
    if (op == 2'b00) q1 = data;
    else if (n == 0 || (op == 2'b11 && !RotEn)) q1 = q0;
    else if (op == 2'b10) begin
      s  = {q0, f8, f8};
      sv = s << n;
      w  = {8'h00, s};
      wv = w << n;
      q1 = sv[23:16];
      o1 = wv[31:24];
    end else begin
      s  = (op == 2'b11) ? {q0, q0, q0} : {f8, f8, q0};
      sv = s >> n;
      w  = {s, 8'h00};
      wv = w >> n;
      q1 = sv[7:0];
      o1 = wv[7:0];
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (cmd_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= 40) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: cmd_ready stayed %b", cmd_ready);
    end
  endtask

  task automatic push_trace(input logic [1:0] op, input int n, input logic fill, output int len);
    exp_t e;
    len = 0;
    if (op != 2'b00 && n != 0 && !(op == 2'b11 && !RotEn)) begin
      for (int i = 0; i < n; i++) begin
        e      = '0;
        e.sel  = (op == 2'b10) ? 2'b10 : 2'b01;
        e.busy = 1'b1;
        e.rot  = (op == 2'b11);
        e.in_r = (op == 2'b01) ? fill : 1'b0;
        e.in_l = (op == 2'b10) ? fill : 1'b0;
        eq.push_back(e);
        len++;
      end
    end else if (op == 2'b00) begin
      e      = '0;
      e.sel  = 2'b11;
      e.busy = 1'b1;
      eq.push_back(e);
      len++;
    end
    e      = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    e.err  = (op == 2'b11) && !RotEn;
    eq.push_back(e);
    len++;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] data,
                         input logic fill, input bit lit, input logic [7:0] lit_q,
                         input logic [7:0] lit_out);
    logic [7:0] mq, mo;
    int len;
    wait_ready();
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    @(posedge clk);
    last_data = data;
    push_trace(op, (op == 2'b00) ? 0 : int'(cnt), fill, len);
    model_cmd(op, int'(cnt), model_q, data, fill, mq, mo);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_fill  = ~fill;
    cmd_count = ~cnt;
    repeat (len) @(negedge clk);
    check("q", {24'd0, plant_q}, {24'd0, mq});
    check("out_bits", {24'd0, out_bits}, {24'd0, mo});
    if (lit) begin
      check("q_lit", {24'd0, plant_q}, {24'd0, lit_q});
      check("out_bits_lit", {24'd0, out_bits}, {24'd0, lit_out});
    end
    model_q = mq;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] mq, mo;
    int len;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sel", {30'd0, sr_sel}, 32'd0);
    check("rst_pin", {24'd0, sr_parallel_in}, 32'd0);
    check("rst_in_L", {31'd0, sr_serial_in_L}, 32'd0);
    check("rst_in_R", {31'd0, sr_serial_in_R}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_out_bits", {24'd0, out_bits}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd0);
    rst       = 1'b0;
    plant_clr = 1'b0;
    @(negedge clk);
    #1 chk_en = 1'b1;

    run_cmd(2'b00, 4'd7, 8'hA5, 1'b0, 1'b1, 8'hA5, 8'h00);
    run_cmd(2'b01, 4'd4, 8'h11, 1'b1, 1'b1, 8'hFA, 8'h50);
    run_cmd(2'b00, 4'd0, 8'h81, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd(2'b10, 4'd3, 8'h22, 1'b0, 1'b1, 8'h08, 8'h04);
    run_cmd(2'b00, 4'd0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd(2'b11, 4'd1, 8'h33, 1'b0, 1'b1, RotEn ? 8'h80 : 8'h01, RotEn ? 8'h80 : 8'h00);
    run_cmd(2'b01, 4'd0, 8'h44, 1'b1, 1'b1, RotEn ? 8'h80 : 8'h01, 8'h00);
    run_cmd(2'b00, 4'd0, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd(2'b01, 4'd12, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd(2'b00, 4'd0, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd(2'b10, 4'd9, 8'h66, 1'b1, 1'b1, 8'hFF, 8'h87);
    run_cmd(2'b00, 4'd0, 8'h96, 1'b0, 1'b0, 8'h00, 8'h00);
    run_cmd(2'b11, 4'd15, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset during the second cycle of a 6-shift SHR: two shifts land, no done.
    run_cmd(2'b00, 4'd0, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_ready();
    cmd_op    = 2'b01;
    cmd_count = 4'd6;
    cmd_data  = 8'h5A;
    cmd_fill  = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    last_data = 8'h5A;
    push_trace(2'b01, 6, 1'b1, len);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst    = 1'b1;
    eq.delete();
    @(posedge clk);
    #1;
    check("mid_rst_sel", {30'd0, sr_sel}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_rst_out_bits", {24'd0, out_bits}, 32'd0);
    rst       = 1'b0;
    last_data = 8'h00;
    @(negedge clk);
    model_cmd(2'b01, 2, model_q, 8'h00, 1'b1, mq, mo);
    check("mid_rst_q", {24'd0, plant_q}, {24'd0, mq});
    check("mid_rst_q_lit", {24'd0, plant_q}, 32'hD6);
    check("post_rst_done", {31'd0, done}, 32'd0);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    model_q = mq;
    #1 chk_en = 1'b1;

    run_cmd(2'b10, 4'd1, 8'h0F, 1'b1, 1'b1, 8'hAD, 8'h01);
    repeat (3) @(negedge clk);
    #1 chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
